// File: rtl/alu_loader_pkg.sv
// alu_loader_pkg: loader state encoding, ALU opcodes and the stage LED helper
package alu_loader_pkg;
  typedef enum logic [1:0] {WAIT_A = 2'd0, WAIT_B = 2'd1, WAIT_OP = 2'd2, SHOW = 2'd3} state_t;
  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_OR  = 2'b10;
  localparam logic [1:0] OP_AND = 2'b11;
  function automatic logic [3:0] stage_led(state_t s);
    return 4'b0001 << s;
  endfunction
endpackage

// File: rtl/rise_edge_detector.sv
// rise_edge_detector: registered one-cycle pulse on each rising edge of in
module rise_edge_detector (
  input  logic clk,
  input  logic reset,
  input  logic in,
  output logic pulse
);
  logic r_prev;
  // track the previous level and pulse for one cycle when a rise is seen
  always_ff @(posedge clk)
    if (reset) begin
      r_prev <= 1'b0;
      pulse  <= 1'b0;
    end else begin
      r_prev <= in;
      pulse  <= in & ~r_prev;
    end
endmodule

// File: rtl/alu_operand_loader.sv
// alu_operand_loader: captures A, B, OpCode from switches on Enter; LOADER_EDGE_DETECT_EN turns Enter into a rise-edge event
module alu_operand_loader
  import alu_loader_pkg::*;
#(
  parameter int M = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [M-1:0] DataIn,
  input  logic         Enter,
  input  logic         Cancel,
  output logic [M-1:0] A,
  output logic [M-1:0] B,
  output logic [1:0]   OpCode,
  output logic         OpValid,
  output logic [3:0]   StageLeds
);
  state_t r_state, w_next;
  logic   w_enter_ev, w_cap_a, w_cap_b, w_cap_op;
`ifdef LOADER_EDGE_DETECT_EN
  rise_edge_detector u_edge (.clk(clk), .reset(reset), .in(Enter), .pulse(w_enter_ev));
`else
  assign w_enter_ev = Enter;
`endif
  // next state and capture strobes; Cancel overrides any advance
  always_comb begin
    w_next   = r_state;
    w_cap_a  = 1'b0;
    w_cap_b  = 1'b0;
    w_cap_op = 1'b0;
    if (Cancel)
      w_next = WAIT_A;
    else if (w_enter_ev)
      case (r_state)
        WAIT_A:  begin w_next = WAIT_B;  w_cap_a  = 1'b1; end
        WAIT_B:  begin w_next = WAIT_OP; w_cap_b  = 1'b1; end
        WAIT_OP: begin w_next = SHOW;    w_cap_op = 1'b1; end
        default: w_next = WAIT_A;
      endcase
  end
  // state, operand registers and LEDs; operands persist across new sequences
  always_ff @(posedge clk)
    if (reset) begin
      r_state   <= WAIT_A;
      A         <= '0;
      B         <= '0;
      OpCode    <= OP_ADD;
      OpValid   <= 1'b0;
      StageLeds <= stage_led(WAIT_A);
    end else begin
      r_state   <= w_next;
      StageLeds <= stage_led(w_next);
      OpValid   <= w_cap_op;
      if (w_cap_a) A <= DataIn;
      if (w_cap_b) B <= DataIn;
      if (w_cap_op) OpCode <= DataIn[1:0];
    end
endmodule

// File: tb/tb_alu_operand_loader.sv
// tb_alu_operand_loader: directed and random stimulus checked against a sequence-level model
module tb_alu_operand_loader;
  import alu_loader_pkg::*;
  logic       clk = 0, reset = 1, Enter = 0, Cancel = 0;
  logic [7:0] DataIn = 0, A, B;
  logic [1:0] OpCode;
  logic       OpValid;
  logic [3:0] StageLeds;
  int checks = 0, failures = 0, n_valid = 0;

  alu_operand_loader #(.M(8)) dut (
    .clk(clk), .reset(reset), .DataIn(DataIn), .Enter(Enter), .Cancel(Cancel),
    .A(A), .B(B), .OpCode(OpCode), .OpValid(OpValid), .StageLeds(StageLeds)
  );

  always #5 clk = ~clk;

  // model: position in the A,B,Op,Show sequence plus the last captured values
  logic [7:0] m_regs [3];
  logic       m_valid, m_init = 0, m_prev, m_pulse, ev;
  int         m_pos;
  always @(posedge clk) begin
`ifdef LOADER_EDGE_DETECT_EN
    ev = m_pulse;
    m_pulse = Enter && !m_prev;
    m_prev = Enter;
`else
    ev = Enter;
`endif
    if (reset) begin
      m_regs[0] = 0; m_regs[1] = 0; m_regs[2] = 0;
      m_pos = 0; m_valid = 0; m_init = 1; m_prev = 0; m_pulse = 0;
    end else begin
      m_valid = 0;
      if (Cancel) m_pos = 0;
      else if (ev) begin
        if (m_pos < 2) m_regs[m_pos] = DataIn;
        if (m_pos == 2) begin
          m_regs[2] = {6'd0, DataIn[1:0]};
          m_valid = 1;
        end
        m_pos = (m_pos + 1) % 4;
      end
    end
  end

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h at %0t", n, act, exp, $time);
    end
  endtask

  // compare every cycle once the model has seen a reset
  always @(negedge clk) begin
    if (OpValid === 1'b1) n_valid++;
    if (m_init) begin
      chk("A", A, m_regs[0]);
      chk("B", B, m_regs[1]);
      chk("OpCode", OpCode, m_regs[2]);
      chk("OpValid", OpValid, m_valid);
      chk("StageLeds", StageLeds, 32'(1 << m_pos));
    end
  end

  task automatic press(input logic [7:0] d);
    @(negedge clk); DataIn = d; Enter = 1;
    @(negedge clk); Enter = 0;
    @(negedge clk);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    reset = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("idle_leds", StageLeds, 4'b0001);
      chk("idle_a", A, 0);
      chk("idle_valid", OpValid, 0);
    end
    n_valid = 0;
    press(8'h3C); press(8'h05); press({6'd0, OP_SUB});
    chk("load_a", A, 8'h3C);
    chk("load_b", B, 8'h05);
    chk("load_op", OpCode, OP_SUB);
    chk("load_leds", StageLeds, 4'b1000);
    chk("load_pulses", n_valid, 1);
    chk("alu_result", 8'(A - B), 8'h37);
    press(8'hEE);
    chk("show_exit_leds", StageLeds, 4'b0001);
    chk("show_exit_a", A, 8'h3C);
    press(8'h7F); press(8'h01);
    n_valid = 0;
    @(negedge clk); Cancel = 1;
    @(negedge clk); Cancel = 0;
    @(negedge clk);
    chk("cancel_leds", StageLeds, 4'b0001);
    chk("cancel_op", OpCode, OP_SUB);
    chk("cancel_a", A, 8'h7F);
    chk("cancel_pulses", n_valid, 0);
    press(8'h11);
    @(negedge clk); DataIn = 8'hAA; Enter = 1; Cancel = 1;
    @(negedge clk); Enter = 0;
    @(negedge clk); Cancel = 0;
    @(negedge clk);
    chk("both_b", B, 8'h01);
    chk("both_a", A, 8'h11);
    chk("both_leds", StageLeds, 4'b0001);
    @(negedge clk); DataIn = 8'h5A; Enter = 1;
    repeat (20) @(negedge clk);
    Enter = 0;
    repeat (2) @(negedge clk);
    chk("held_a", A, 8'h5A);
`ifdef LOADER_EDGE_DETECT_EN
    chk("held_leds", StageLeds, 4'b0010);
    chk("held_b", B, 8'h01);
`else
    chk("held_leds", StageLeds, 4'b0001);
    chk("held_b", B, 8'h5A);
`endif
    @(negedge clk); Cancel = 1;
    @(negedge clk); Cancel = 0;
    press(8'h33); press(8'h44);
    chk("pre_reset_leds", StageLeds, 4'b0100);
    @(negedge clk); reset = 1; DataIn = 8'h03; Enter = 1;
    @(negedge clk); reset = 0; Enter = 0;
    chk("rst_a", A, 0);
    chk("rst_b", B, 0);
    chk("rst_op", OpCode, OP_ADD);
    chk("rst_valid", OpValid, 0);
    chk("rst_leds", StageLeds, 4'b0001);
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      DataIn = 8'($urandom);
      Enter  = ($urandom_range(0, 2) == 0);
      Cancel = ($urandom_range(0, 9) == 0);
      reset  = ($urandom_range(0, 63) == 0);
    end
    @(negedge clk); reset = 0; Enter = 0; Cancel = 0;
    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
